core_b_arbiter: RTL and testbench

Central arbiter for the Core-B Lite on-chip high-speed bus. It accepts the request, lock and burst-length outputs of up to eight master wrappers and drives a one-hot grant back to them. It holds ownership from grant through the final data phase of the accepted burst, and for locked sequences keeps the same owner across bursts. The binary owner index it exports drives the bus address/write-data multiplexers.

---
 rtl/core_b_arbiter.sv | 130 +++++++++++++
 tb/tb_core_b_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/core_b_arbiter.sv
`default_nettype none
// ============================================================================
// core_b_arbiter
// Core-B Lite bus arbiter. It grants one master at a time and holds the grant
// through the accepted burst. Locked sequences keep the same owner.
// Optional build macro: ARB_FIXED_PRIO_EN (lowest index wins instead of
// round robin).
// Revision: 1.0
// ============================================================================
module core_b_arbiter #(
    parameter int NUM_MST = 4,
    parameter int IDW     = 2
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [NUM_MST-1:0]     MxREQ,
    input  logic [NUM_MST-1:0]     MxLK,
    input  logic [4*NUM_MST-1:0]   MxRB,
    input  logic                   MsRDY,
    input  logic                   MsERR,
    output logic [NUM_MST-1:0]     AxGNT,
    output logic [IDW-1:0]         AxMST,
    output logic                   AxBUSY,
    output logic                   AxLOCKED
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2
    } state_t;

    state_t              state;
    logic [IDW-1:0]      owner;
    logic [IDW-1:0]      last_owner;
    logic [3:0]          beats;
    logic                lock_r;
    logic [NUM_MST-1:0]  gnt;
    logic                busy;

    logic [IDW-1:0]      winner;
    logic                any_req;
    logic                own_req;
    logic                own_lk;
    logic [3:0]          own_rb;

    assign any_req = |MxREQ;
    assign own_req = MxREQ[owner];
    assign own_lk  = MxLK[owner];
    assign own_rb  = MxRB[4*int'(owner) +: 4];

    // Loops run from lowest priority to highest so the last hit is the winner.
    always_comb begin
        winner = '0;
`ifdef ARB_FIXED_PRIO_EN
        for (int i = NUM_MST - 1; i >= 0; i--) begin
            if (MxREQ[i]) winner = IDW'(i);
        end
`else
        for (int k = NUM_MST; k >= 1; k--) begin
            if (MxREQ[(int'(last_owner) + k) % NUM_MST])
                winner = IDW'((int'(last_owner) + k) % NUM_MST);
        end
`endif
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= IDW'(NUM_MST - 1);
            beats      <= '0;
            lock_r     <= 1'b0;
            gnt        <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner <= winner;
                        gnt   <= {{(NUM_MST-1){1'b0}}, 1'b1} << winner;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (own_req && MsRDY) begin
                        beats  <= own_rb;
                        lock_r <= own_lk;
                        busy   <= 1'b1;
                        state  <= XFER;
                    end else if (!own_req) begin
                        last_owner <= owner;
                        gnt        <= '0;
                        state      <= IDLE;
                    end
                end
                XFER: begin
                    if (MsRDY) begin
                        if (beats != 4'd0 && !MsERR) begin
                            beats <= beats - 4'd1;
                        end else begin
                            busy <= 1'b0;
                            // A held lock re-enters GRANT with no arbitration bubble.
                            if (lock_r && own_req) begin
                                state <= GRANT;
                            end else begin
                                lock_r     <= 1'b0;
                                last_owner <= owner;
                                gnt        <= '0;
                                state      <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign AxGNT    = gnt;
    assign AxMST    = owner;
    assign AxBUSY   = busy;
    assign AxLOCKED = lock_r;

endmodule
`default_nettype wire

// File: tb/tb_core_b_arbiter.sv
`default_nettype none
// ============================================================================
// tb_core_b_arbiter
// Vector tables with a scoreboard queue, plus hand sequences for async reset.
// Revision: 1.0
// ============================================================================
module tb_core_b_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [3:0]  MxREQ;
    logic [3:0]  MxLK;
    logic [15:0] MxRB;
    logic        MsRDY;
    logic        MsERR;
    logic [3:0]  AxGNT;
    logic [1:0]  AxMST;
    logic        AxBUSY;
    logic        AxLOCKED;

    core_b_arbiter #(.NUM_MST(4), .IDW(2)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .MxREQ    (MxREQ),
        .MxLK     (MxLK),
        .MxRB     (MxRB),
        .MsRDY    (MsRDY),
        .MsERR    (MsERR),
        .AxGNT    (AxGNT),
        .AxMST    (AxMST),
        .AxBUSY   (AxBUSY),
        .AxLOCKED (AxLOCKED)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  lk;
        logic [15:0] rb;
        logic        rdy;
        logic        err;
        logic [3:0]  gnt;
        logic [1:0]  mst;
        logic        busy;
        logic        locked;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;

    function automatic logic [15:0] rb(input int m, input logic [3:0] v);
        logic [15:0] r;
        r = 16'(v) << (4 * m);
        return r;
    endfunction

    function automatic void add(input logic [3:0] req, input logic [3:0] lk,
                                input logic [15:0] rbv, input logic rdy, input logic err,
                                input logic [3:0] gnt, input logic [1:0] mst,
                                input logic busy, input logic locked);
        vec_t v;
        v.req = req; v.lk = lk; v.rb = rbv; v.rdy = rdy; v.err = err;
        v.gnt = gnt; v.mst = mst; v.busy = busy; v.locked = locked;
        tbl.push_back(v);
    endfunction

    function automatic logic [7:0] outs();
        return {AxGNT, AxMST, AxBUSY, AxLOCKED};
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got gnt=%b mst=%0d busy=%b locked=%b, required gnt=%b mst=%0d busy=%b locked=%b",
                     name, got[7:4], got[3:2], got[1], got[0], exp[7:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            MxREQ = tbl[i].req;
            MxLK  = tbl[i].lk;
            MxRB  = tbl[i].rb;
            MsRDY = tbl[i].rdy;
            MsERR = tbl[i].err;
            exp_q.push_back({tbl[i].gnt, tbl[i].mst, tbl[i].busy, tbl[i].locked});
            @(posedge CLK);
            #1;
            check($sformatf("%s[%0d]", name, i), outs(), exp_q.pop_front());
        end
        tbl.delete();
    endtask

    // Asserts reset away from the clock edge and checks outputs clear at once.
    task automatic do_reset(input string name);
        #2;
        nRST = 1'b0;
        #1;
        check({name, "_async"}, outs(), 8'h00);
        @(posedge CLK);
        #1;
        check({name, "_held"}, outs(), 8'h00);
        nRST = 1'b1;
    endtask

    initial begin
        nRST  = 1'b0;
        MxREQ = '0; MxLK = '0; MxRB = '0; MsRDY = 1'b0; MsERR = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_values", outs(), 8'h00);
        nRST = 1'b1;

        // Single-beat transfer by master 0
        add(4'b0001, 4'b0, 16'h0, 1, 0, 4'b0001, 2'd0, 0, 0);
        add(4'b0001, 4'b0, 16'h0, 1, 0, 4'b0001, 2'd0, 1, 0);
        add(4'b0000, 4'b0, 16'h0, 1, 0, 4'b0000, 2'd0, 0, 0);
        add(4'b0000, 4'b0, 16'h0, 0, 0, 4'b0000, 2'd0, 0, 0);
        run_table("single");

        do_reset("rst_idle");

        // Round robin 0,1,2,3,0 with one IDLE bubble between grants
        for (int m = 0; m < 4; m++) begin
            add(4'b1111, 4'b0, 16'h0, 1, 0, 4'b0001 << m, 2'(m), 0, 0);
            add(4'b1111, 4'b0, 16'h0, 1, 0, 4'b0001 << m, 2'(m), 1, 0);
            add(4'b1111, 4'b0, 16'h0, 1, 0, 4'b0000,      2'(m), 0, 0);
        end
        add(4'b1111, 4'b0, 16'h0, 1, 0, 4'b0001, 2'd0, 0, 0);
        add(4'b0000, 4'b0, 16'h0, 1, 0, 4'b0000, 2'd0, 0, 0);
        run_table("rr");

        // Master 2, four beats with stalls; MsERR without MsRDY is ignored
        add(4'b0100, 4'b0, rb(2, 3), 0, 0, 4'b0100, 2'd2, 0, 0);
        add(4'b0100, 4'b0, rb(2, 3), 1, 0, 4'b0100, 2'd2, 1, 0);
        add(4'b0100, 4'b0, rb(2, 3), 0, 0, 4'b0100, 2'd2, 1, 0);
        add(4'b0100, 4'b0, rb(2, 3), 1, 0, 4'b0100, 2'd2, 1, 0);
        add(4'b0100, 4'b0, rb(2, 3), 0, 1, 4'b0100, 2'd2, 1, 0);
        add(4'b0100, 4'b0, rb(2, 3), 1, 0, 4'b0100, 2'd2, 1, 0);
        add(4'b0100, 4'b0, rb(2, 3), 0, 0, 4'b0100, 2'd2, 1, 0);
        add(4'b0100, 4'b0, rb(2, 3), 1, 0, 4'b0100, 2'd2, 1, 0);
        add(4'b0100, 4'b0, rb(2, 3), 0, 0, 4'b0100, 2'd2, 1, 0);
        add(4'b0000, 4'b0, rb(2, 3), 1, 0, 4'b0000, 2'd2, 0, 0);
        add(4'b0000, 4'b0, rb(2, 3), 0, 0, 4'b0000, 2'd2, 0, 0);
        run_table("stall");

        // Locked master 1 over two bursts while master 0 waits
        add(4'b0010, 4'b0010, rb(1, 1), 0, 0, 4'b0010, 2'd1, 0, 0);
        add(4'b0011, 4'b0010, rb(1, 1), 1, 0, 4'b0010, 2'd1, 1, 1);
        add(4'b0011, 4'b0010, rb(1, 1), 1, 0, 4'b0010, 2'd1, 1, 1);
        add(4'b0011, 4'b0010, rb(1, 1), 1, 0, 4'b0010, 2'd1, 0, 1);
        add(4'b0011, 4'b0010, rb(1, 1), 1, 0, 4'b0010, 2'd1, 1, 1);
        add(4'b0011, 4'b0010, rb(1, 1), 1, 0, 4'b0010, 2'd1, 1, 1);
        add(4'b0001, 4'b0010, rb(1, 1), 1, 0, 4'b0000, 2'd1, 0, 0);
        add(4'b0001, 4'b0000, 16'h0,    0, 0, 4'b0001, 2'd0, 0, 0);
        add(4'b0000, 4'b0000, 16'h0,    0, 0, 4'b0000, 2'd0, 0, 0);
        run_table("lock");

        // Error on beat 2 of a six-beat burst, then a new burst
        add(4'b1000, 4'b0, rb(3, 5), 0, 0, 4'b1000, 2'd3, 0, 0);
        add(4'b1000, 4'b0, rb(3, 5), 1, 0, 4'b1000, 2'd3, 1, 0);
        add(4'b1000, 4'b0, rb(3, 5), 1, 0, 4'b1000, 2'd3, 1, 0);
        add(4'b1000, 4'b0, rb(3, 5), 1, 1, 4'b0000, 2'd3, 0, 0);
        add(4'b1000, 4'b0, rb(3, 5), 0, 0, 4'b1000, 2'd3, 0, 0);
        add(4'b1000, 4'b0, rb(3, 5), 1, 0, 4'b1000, 2'd3, 1, 0);
        run_table("error");

        do_reset("rst_xfer");

        // After reset master 0 has first priority
        add(4'b1111, 4'b0, 16'h0, 0, 0, 4'b0001, 2'd0, 0, 0);
        add(4'b0000, 4'b0, 16'h0, 0, 0, 4'b0000, 2'd0, 0, 0);
        run_table("post_rst");

        // Masters 1 and 2 requesting: fixed priority keeps master 1
        add(4'b0110, 4'b0, 16'h0, 1, 0, 4'b0010, 2'd1, 0, 0);
        add(4'b0110, 4'b0, 16'h0, 1, 0, 4'b0010, 2'd1, 1, 0);
        add(4'b0110, 4'b0, 16'h0, 1, 0, 4'b0000, 2'd1, 0, 0);
`ifdef ARB_FIXED_PRIO_EN
        add(4'b0110, 4'b0, 16'h0, 1, 0, 4'b0010, 2'd1, 0, 0);
        add(4'b0110, 4'b0, 16'h0, 1, 0, 4'b0010, 2'd1, 1, 0);
        add(4'b0110, 4'b0, 16'h0, 1, 0, 4'b0000, 2'd1, 0, 0);
`else
        add(4'b0110, 4'b0, 16'h0, 1, 0, 4'b0100, 2'd2, 0, 0);
        add(4'b0110, 4'b0, 16'h0, 1, 0, 4'b0100, 2'd2, 1, 0);
        add(4'b0110, 4'b0, 16'h0, 1, 0, 4'b0000, 2'd2, 0, 0);
`endif
        add(4'b0110, 4'b0, 16'h0, 1, 0, 4'b0010, 2'd1, 0, 0);
        add(4'b0000, 4'b0, 16'h0, 1, 0, 4'b0000, 2'd1, 0, 0);
        run_table("prio");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
